// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the pipeline (master) and the multiply/divide unit (slave).
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, we_hi, we_lo, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, we_hi, we_lo, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Optional feature macro MD_MADD_EN builds madd/maddu/msub/msubu accumulate ops (4-7).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      rst_n,
  md_unit_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
`ifdef MD_MADD_EN
  logic [1:0]  acc_q;
`endif

  logic        is_div, op_ok, launch;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] mul_res;

  assign is_div = (bus.md_op[2:1] == 2'b01);
`ifdef MD_MADD_EN
  assign op_ok  = 1'b1;
`else
  assign op_ok  = ~bus.md_op[2];
`endif
  assign launch = bus.start && (state == IDLE) && op_ok;

  // Sign-extending before a 64x64 multiply makes the low 64 bits the exact signed product.
  assign a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign prod  = a_ext * b_ext;

  // Signed divide via magnitudes: avoids overflow on 0x80000000 / -1, which then falls out correctly.
  assign a_mag = (sgn_q && a_q[31]) ? -a_q : a_q;
  assign b_mag = (sgn_q && b_q[31]) ? -b_q : b_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  assign quot = (sgn_q && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
  assign rem  = (sgn_q && a_q[31]) ? -r_mag : r_mag;

  always_comb begin
    mul_res = prod;
`ifdef MD_MADD_EN
    case (acc_q)
      2'b10:   mul_res = {hi_q, lo_q} + prod;
      2'b11:   mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; every register, operands included, is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
`ifdef MD_MADD_EN
      acc_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            sgn_q  <= ~bus.md_op[0];
`ifdef MD_MADD_EN
            acc_q  <= bus.md_op[2:1];
`endif
            cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state  <= is_div ? DIV : MUL;
            busy_q <= 1'b1;
          end else if (!bus.start) begin
            if (bus.we_hi) hi_q <= bus.wdata;
            if (bus.we_lo) lo_q <= bus.wdata;
          end
        end
        MUL, DIV: begin
          if (cnt <= CW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (state == MUL) begin
              {hi_q, lo_q} <= mul_res;
            end else if (b_q != '0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences, random ops vs. model.
module tb_md_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  md_unit_if bus ();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0;
    bus.md_op = '0; bus.a = '0; bus.b = '0; bus.wdata = '0;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk); bus.we_hi = 1'b1; bus.wdata = h;
    @(negedge clk); bus.we_hi = 1'b0; bus.we_lo = 1'b1; bus.wdata = l;
    @(negedge clk); bus.we_lo = 1'b0;
  endtask

  // Launch one op and count busy cycles; returns at the first negedge with busy low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int n);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (scramble) begin bus.a = $urandom; bus.b = $urandom; end
      n++;
      @(negedge clk);
    end
  endtask

  // Reference model straight from the architectural definitions, in 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc,
                                        output int cyc);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    int ia = $signed(a);
    int ib = $signed(b);
    logic [31:0] q, r;
    model = acc;
    cyc   = (op == 3'd2 || op == 3'd3) ? 10 : 5;
    case (op)
      3'd0: model = sa * sb;
      3'd1: model = ua * ub;
      3'd2: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin q = ia / ib; r = ia % ib; model = {r, q}; end
      end
      3'd3: if (b != 0) begin q = a / b; r = a % b; model = {r, q}; end
      default: begin
        if (!MADD) cyc = 0;
        else case (op)
          3'd4: model = acc + sa * sb;
          3'd5: model = acc + ua * ub;
          3'd6: model = acc - sa * sb;
          default: model = acc - ua * ub;
        endcase
      end
    endcase
  endfunction

  vec_t vecs[$];
  int   n;
  bit   seen99;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);

    // First rising edge after reset release must accept start.
    rst_n = 1'b1; bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'd4; bus.b = 32'd5;
    @(negedge clk); bus.start = 1'b0;
    check("first_edge_busy", bus.busy, 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("first_edge_cycles", n, 5);
    check("first_edge_lo", {bus.hi, bus.lo}, 64'd20);

    vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'h2, 32'hFFFF_FFFA, 5});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    vecs.push_back('{3'd3, 32'd7, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 10});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3, 4, 32'h0, 32'h8000_0000, 10});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd16, 0, 0, 32'hF, 32'h0FFF_FFFF, 10});
    vecs.push_back('{3'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'h1, 32'hFFFF_FFFD, 10});
    if (MADD) begin
      vecs.push_back('{3'd5, 32'd1, 32'd1, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5});
      vecs.push_back('{3'd6, 32'd1, 32'd2, 1, 0, 32'h0, 32'hFFFF_FFFE, 5});
    end else begin
      vecs.push_back('{3'd5, 32'd1, 32'd1, 0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0});
      vecs.push_back('{3'd6, 32'd1, 32'd2, 1, 0, 32'h1, 32'h0, 0});
    end

    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
    end

    // start (div) and mthi during a mult are both ignored.
    set_hilo(32'h0, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      if (n == 2) begin
        bus.start = 1'b1; bus.md_op = 3'd2; bus.a = 32'd100; bus.b = 32'd3;
        bus.we_hi = 1'b1; bus.wdata = 32'h55;
      end else begin
        bus.start = 1'b0; bus.we_hi = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
    check("busy_ignore_cycles", n, 5);
    check("busy_ignore_result", {bus.hi, bus.lo}, 64'd42);
    repeat (3) @(negedge clk);
    check("busy_ignore_no_relaunch", bus.busy, 0);

    // Reset during busy cycle 3 of a div discards the pending result.
    set_hilo(32'h1234, 32'h5678);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset_busy_before", bus.busy, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_reset_busy", bus.busy, 0);
    check("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_reset_no_update", {bus.hi, bus.lo}, 64'd0);
    check("mid_reset_idle", bus.busy, 0);

    // start and mtlo in the same idle cycle: start wins.
    set_hilo(32'h0, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'd2; bus.b = 32'd3;
    bus.we_lo = 1'b1; bus.wdata = 32'h99;
    @(negedge clk); idle_inputs();
    seen99 = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.lo == 32'h99) seen99 = 1'b1;
      n++;
      @(negedge clk);
    end
    check("start_wins_no_99", seen99, 0);
    check("start_wins_cycles", n, 5);
    check("start_wins_result", {bus.hi, bus.lo}, 64'd6);

    // Random ops against the model; operands scrambled while busy.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] ra, rb, h, l;
      logic [63:0] exp;
      int          ecyc;
      op = MADD ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      if (i % 10 == 9) op = 3'($urandom_range(4, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      h = $urandom; l = $urandom;
      set_hilo(h, l);
      exp = model(op, ra, rb, {h, l}, ecyc);
      run_op(op, ra, rb, 1'b1, n);
      check($sformatf("rand%0d_op%0d_cycles", i, op), n, ecyc);
      check($sformatf("rand%0d_op%0d_hilo", i, op), {bus.hi, bus.lo}, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
